// File: rtl/keypad_scanner_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 hex keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Element index is {row, col}; element 0 (row0/col0) is the lowest nibble.
    localparam logic [15:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Purpose  : Keypad matrix lines plus the decoded key report.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Purpose  : Column-step prescaler; emits a tick and the current column index.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [1:0] col_idx
);
    localparam int                c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col;

    assign tick    = (r_div == c_div_last);
    assign col_idx = r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_col <= '0;
        end else if (tick) begin
            r_div <= '0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 hex keypad, rejects ghosts, debounces, reports keys.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    import keypad_pkg::*;

    localparam logic [3:0] c_cnt_target = 4'(DEBOUNCE_SCANS);

    logic [3:0] r_rows_meta;
    logic [3:0] r_rows_sync;
    logic       w_tick;
    logic [1:0] w_col_idx;
    logic [3:0] r_cols;

    logic [1:0] r_acc_hits;
    logic [3:0] r_acc_code;
    logic [2:0] w_low_cnt;
    logic [1:0] w_row_idx;
    logic [2:0] w_sum;
    logic [1:0] w_hits_next;
    logic [3:0] w_code_next;
    logic       w_sweep_done;
    logic       w_single;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_inc;
    logic [3:0] r_cand;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_key_held;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick    (w_tick),
        .col_idx (w_col_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows_meta <= 4'b1111;
            r_rows_sync <= 4'b1111;
        end else begin
            r_rows_meta <= kp.rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cols <= COL_RESET;
        end else if (w_tick) begin
            case (r_cols)
                4'b1110: r_cols <= 4'b1101;
                4'b1101: r_cols <= 4'b1011;
                4'b1011: r_cols <= 4'b0111;
                default: r_cols <= COL_RESET;
            endcase
        end
    end

    // Hit count saturates at 2: anything beyond one low bit is a ghost sweep.
    always_comb begin
        w_low_cnt = '0;
        w_row_idx = '0;
        for (int r = 0; r < 4; r++) begin
            if (!r_rows_sync[r]) begin
                w_low_cnt = w_low_cnt + 3'd1;
                w_row_idx = 2'(r);
            end
        end
        w_sum       = w_low_cnt + {1'b0, r_acc_hits};
        w_hits_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_code_next = (r_acc_hits == 2'd0 && w_low_cnt == 3'd1)
                    ? key_lookup(w_row_idx, w_col_idx) : r_acc_code;
    end

    assign w_sweep_done = w_tick && (w_col_idx == 2'd3);
    assign w_single     = (w_hits_next == 2'd1);
    assign w_cnt_inc    = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_sweep_done) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_tick) begin
            r_acc_hits <= w_hits_next;
            r_acc_code <= w_code_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_sweep_done) begin
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_cand <= w_code_next;
                            if (DEBOUNCE_SCANS <= 1) begin
                                r_state     <= PRESSED;
                                r_cnt       <= '0;
                                r_key_code  <= w_code_next;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_state <= DEBOUNCE;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (w_single && w_code_next == r_cand) begin
                            if (w_cnt_inc >= c_cnt_target) begin
                                r_state     <= PRESSED;
                                r_cnt       <= '0;
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!w_single) begin
                            if (DEBOUNCE_SCANS <= 1) begin
                                r_state    <= IDLE;
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                            end else begin
                                r_state <= RELEASE;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (w_single) begin
                            r_state <= PRESSED;
                            r_cnt   <= '0;
                        end else if (w_cnt_inc >= c_cnt_target) begin
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_key_held <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign kp.cols      = r_cols;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Keypad matrix model, sweep-level reference model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pressed;   // bit (row*4 + col) set when that key is down

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    bit m_held      = 1'b0;
    int m_run       = 0;
    int m_code      = 0;
    int m_last_code = 0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] keys);
        logic [3:0] v;
        v = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!cols[c])
                for (int r = 0; r < 4; r++)
                    if (keys[r*4 + c]) v[r] = 1'b0;
        return v;
    endfunction

    assign kif.rows = rows_for(kif.cols, pressed);

    function automatic int code_at(input int pos);
        int tbl[16];
        tbl = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
        return tbl[pos];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full sweep seen with the given key set; returns whether it yields a report.
    task automatic model_sweep(input logic [15:0] keys, output bit acc);
        int c;
        c   = -1;
        acc = 1'b0;
        if ($countones(keys) == 1)
            for (int p = 0; p < 16; p++) if (keys[p]) c = code_at(p);
        if (!m_held) begin
            if (c < 0)             m_run = 0;
            else if (m_run == 0)   begin m_code = c; m_run = 1; end
            else if (c == m_code)  m_run++;
            else                   m_run = 0;
            if (m_run >= DS) begin
                acc         = 1'b1;
                m_held      = 1'b1;
                m_run       = 0;
                m_last_code = m_code;
                exp_q.push_back(m_code);
            end
        end else begin
            if (c < 0) m_run++;
            else       m_run = 0;
            if (m_run >= DS) begin
                m_held = 1'b0;
                m_run  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_held      = 1'b0;
        m_run       = 0;
        m_code      = 0;
        m_last_code = 0;
    endtask

    task automatic wait_sweep_end(input string name);
        bit seen3;
        bit done;
        seen3 = 1'b0;
        done  = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (kif.cols == 4'b0111) seen3 = 1'b1;
            else if (seen3 && kif.cols == 4'b1110) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.sweep_timeout: got no sweep end, expected one within 64 clk", name);
        end
    endtask

    task automatic do_sweep(input logic [15:0] keys, input string name);
        bit acc;
        model_sweep(keys, acc);
        pressed = keys;
        wait_sweep_end(name);
        check($sformatf("%s.key_valid", name), int'(kif.key_valid), int'(acc));
        check($sformatf("%s.key_held", name),  int'(kif.key_held),  int'(m_held));
        if (!acc) check($sformatf("%s.key_code_hold", name), int'(kif.key_code), m_last_code);
    endtask

    task automatic repeat_sweep(input logic [15:0] keys, input int n, input string name);
        for (int i = 0; i < n; i++) do_sweep(keys, name);
    endtask

    task automatic check_drained(input string name);
        #1;
        check($sformatf("%s.pending_reports", name), exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every key_valid pulse consumes one predicted report.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && kif.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got key_valid=1 code %0h, expected no pulse", kif.key_code);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("key_code", int'(kif.key_code), e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m;
        bit          dummy;
        rst     = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // T1: asynchronous reset mid-count
        #2 rst = 1'b1;
        #1;
        check("t1.rst_cols",      int'(kif.cols),      4'b1110);
        check("t1.rst_key_valid", int'(kif.key_valid), 0);
        check("t1.rst_key_held",  int'(kif.key_held),  0);
        check("t1.rst_key_code",  int'(kif.key_code),  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t1.cols_hold", int'(kif.cols), 4'b1110);
        @(negedge clk);
        check("t1.cols_step", int'(kif.cols), 4'b1101);
        model_sweep(16'h0000, dummy);
        wait_sweep_end("t1");
        check_drained("t1");

        // T2: key 6 (row1/col2) press and release
        repeat_sweep(16'h0001 << 6, DS, "t2_press");
        repeat_sweep(16'h0000, DS, "t2_release");
        check_drained("t2");

        // T3: key 9 bouncing
        repeat_sweep(16'h0001 << 10, 2, "t3_bounce");
        do_sweep(16'h0000, "t3_gap");
        repeat_sweep(16'h0001 << 10, 3, "t3_press");
        repeat_sweep(16'h0000, DS, "t3_release");
        check_drained("t3");

        // T4: ghost keys 1 and D
        repeat_sweep((16'h0001 << 0) | (16'h0001 << 15), 5, "t4_ghost");
        repeat_sweep(16'h0000, DS, "t4_release");
        check_drained("t4");

        // T5: key A then B added and swapped while held
        repeat_sweep(16'h0001 << 3, 3, "t5_a");
        repeat_sweep((16'h0001 << 3) | (16'h0001 << 7), 2, "t5_ab");
        repeat_sweep(16'h0001 << 7, 2, "t5_b_held");
        repeat_sweep(16'h0000, DS, "t5_release");
        repeat_sweep(16'h0001 << 7, 3, "t5_b_fresh");
        repeat_sweep(16'h0000, DS, "t5_release2");
        check_drained("t5");

        // T6: reset in the middle of debouncing key 0
        repeat_sweep(16'h0001 << 12, 2, "t6_pre");
        check_drained("t6_pre");
        pressed = 16'h0001 << 12;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6.rst_key_valid", int'(kif.key_valid), 0);
        check("t6.rst_cols",      int'(kif.cols),      4'b1110);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat_sweep(16'h0001 << 12, 3, "t6_press");
        repeat_sweep(16'h0000, DS, "t6_release");
        check_drained("t6");

        // Randomised key traffic
        m = '0;
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      m = m;
            else if (sel < 7) m = '0;
            else if (sel < 9) m = 16'h0001 << $urandom_range(0, 15);
            else              m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            do_sweep(m, "rand");
        end
        repeat_sweep(16'h0000, DS + 1, "rand_release");
        check_drained("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed 7-segment display driver. The display driver scans anodes and drives cathodes; this block scans a 4x4 hex keypad (PmodKYPD-style). It drives one active-low column at a time and samples the four rows, then debounces the result. It reports each new keypress as a 4-bit hex code with a one-cycle valid pulse, ready to feed the digit registers that currently take their value from switches and buttons.

Parameters:
SCAN_DIV, 100000, clk cycles per column step (same slow-tick rate as the display multiplexer)
DEBOUNCE_SCANS, 4, consecutive identical full sweeps required to accept a press or a release (range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rows  input  4  keypad row lines, active-low, externally pulled up
cols  output  4  keypad column drive, active-low one-hot
key_code  output  4  hex value of the last accepted key; holds until the next accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high from acceptance until the release is accepted

Behaviour:
- Reset values (async, active-high): cols=4'b1110, key_code=0, key_valid=0, key_held=0, state=IDLE. All counters are 0. Row synchroniser flops are 4'b1111.
- rows pass through a 2-flop synchroniser before any use.
- Prescaler counts 0..SCAN_DIV-1 and pulses tick for one cycle on the terminal count.
- On tick:
  - sample the synchronised rows for the currently driven column;
  - then rotate cols: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Any other value returns to 1110.
- Column index: 1110=col0 through 0111=col3. Row index: rows[0]=row0.
- Key map, row-major, col0..col3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Sweep = four consecutive ticks, col0 through col3. A sweep-done strobe fires on the tick that samples col3.
- Sweep result, accumulated across the sweep:
  - NONE: zero low row bits seen;
  - SINGLE(code): exactly one low bit seen across all four columns;
  - MULTI: two or more low bits. MULTI is treated as NONE (ghost rejection).
- FSM, evaluated only on sweep-done:
  - IDLE: SINGLE(c) -> DEBOUNCE with cand=c, cnt=1. If DEBOUNCE_SCANS=1, go straight to PRESSED and accept.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED and accept. SINGLE(other) or NONE -> IDLE with cnt=0.
  - PRESSED: NONE -> RELEASE, cnt=1. SINGLE(any) stays in PRESSED. A different key while held is not reported.
  - RELEASE: NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE and key_held=0. SINGLE(any) -> PRESSED, cnt=0, with no new report.
- Accept: in the cycle after the qualifying sweep-done, key_code=cand and key_valid=1 for exactly one clk. key_held rises in the same cycle.
- key_held stays 1 through PRESSED and RELEASE.
- Reset mid-sweep or mid-debounce discards all progress. No key_valid is emitted by reset.
- cnt saturates; it never wraps.
- Total press latency: DEBOUNCE_SCANS sweeps + up to 1 sweep of alignment + 3 clk (2 sync + 1 output register).

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE};
  - 16-entry key map constant indexed {row,col};
  - COL_RESET = 4'b1110.
- One natural sub-module: scan_tick_gen. It holds the SCAN_DIV prescaler and outputs tick plus a 2-bit column index.
- The FSM, sweep accumulator and output registers stay in keypad_scanner.

Test Plan:
Simulate with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
1. Reset asserted mid-count, then released -> cols=1110, key_valid=0, key_held=0, key_code=0. cols step to 1101 four clk later.
2. Hold row1 low only while cols=1011 (key 6) for 3 sweeps -> exactly one key_valid pulse with key_code=4'h6, key_held=1. Release for 3 sweeps -> key_held=0 and no further pulse.
3. Bounce: key 9 present for 2 sweeps, absent for 1, present for 3 -> single key_valid with key_code=4'h9, asserted only after the final 3-sweep run.
4. Ghost: keys 1 and D pressed together for 5 sweeps -> no key_valid, key_held=0.
5. Key A held, then key B added/swapped without a 3-sweep release -> one pulse for 4'hA only. B is reported only after a full release and a fresh 3-sweep press.
6. Assert rst during DEBOUNCE at cnt=2 with key 0 held, then release rst -> the debounce restarts. key_valid with code 4'h0 fires only after 3 fresh sweeps.
